// File: rtl/pipeline_pkg.sv
// Shared definitions for the ARM pipeline front end: word width, PC step,
// the MOV r0,r0 bubble, fetch state encoding and small arithmetic helpers.
package pipeline_pkg;

  localparam int                  WORD_W    = 32;
  localparam logic [WORD_W-1:0]   PC_INC    = 32'd4;
  localparam logic [WORD_W-1:0]   NOP_WORD  = 32'hE1A0_0000;
  localparam logic [WORD_W-1:0]   COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // A word fetch at addr is legal when the whole word lies inside memory.
  function automatic logic fetch_in_range(input logic [WORD_W-1:0] addr,
                                          input logic [WORD_W-1:0] limit);
    return addr <= (limit - PC_INC);
  endfunction

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + 32'd1;
  endfunction

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a
// valid flag; a flush loads the bubble instead of the incoming word.
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [WORD_W-1:0] next_instr,
  input  logic [WORD_W-1:0] next_pc4,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4,
  output logic              valid
);

  // IF -> ID boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        instr <= NOP_INSTR;
        pc4   <= '0;
        valid <= 1'b0;
      end else begin
        instr <= next_instr;
        pc4   <= next_pc4;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and fetch state, drives instruction memory and
// fills IF/ID, handling stalls, branch redirects and out-of-range halting.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       ADDR_LIMIT = 256,
  parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [WORD_W-1:0] inst_data,
  output logic [WORD_W-1:0] inst_addr,
  output logic              inst_enable,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_count
);

  localparam logic [WORD_W-1:0] LIMIT = WORD_W'(ADDR_LIMIT);

  fetch_state_e      state, state_next;
  logic [WORD_W-1:0] pc, pc_next;
  logic [WORD_W-1:0] count_next;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] target;
  logic              capture;
  logic              ifid_enable;

  assign pc_plus4 = pc + PC_INC;
  assign target   = word_align(branch_target);

  // Priority: branch redirect, then stall, then the per-state fetch action.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = fetch_count;
    capture    = 1'b0;
    if (branch_taken) begin
      pc_next    = target;
      state_next = fetch_in_range(target, LIMIT) ? RUN : HALT;
    end else if (!stall) begin
      if (state == RUN) begin
        if (fetch_in_range(pc, LIMIT)) begin
          capture    = 1'b1;
          pc_next    = pc_plus4;
          count_next = sat_inc(fetch_count);
        end else begin
          state_next = HALT;
        end
      end
    end
  end

  // PC / state / counter boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

  // Branch flushes even during a stall; otherwise IF/ID follows the stall.
  assign ifid_enable = !stall || branch_taken;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .enable     (ifid_enable),
    .flush      (!capture),
    .next_instr (inst_data),
    .next_pc4   (pc_plus4),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4),
    .valid      (ifid_valid)
  );

  assign inst_addr   = pc;
  assign inst_enable = (state == RUN) && !stall && !reset;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations followed by a randomized run against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'hE1A0_0000;
  localparam logic [31:0] LIMIT = 32'd256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] inst_data;
  logic [31:0] inst_addr;
  logic        inst_enable;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  // Behavioural model of the architectural state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halt;
  logic        auto_check = 1'b0;

  int tests = 0;
  int fails = 0;

  fetch_stage #(
    .RESET_PC   (32'h0),
    .ADDR_LIMIT (256),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_data     (inst_data),
    .inst_addr     (inst_addr),
    .inst_enable   (inst_enable),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign inst_data = (inst_addr < LIMIT) ? mem[inst_addr[7:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_halt = 1'b0; m_count = 32'h0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else if (branch_taken) begin
      m_pc    = {branch_target[31:2], 2'b00};
      m_instr = NOP;
      m_valid = 1'b0;
      m_halt  = (m_pc > LIMIT - 4);
    end else if (stall) begin
      // everything holds
    end else if (!m_halt && m_pc <= LIMIT - 4) begin
      m_instr = mem[m_pc[7:2]];
      m_pc4   = m_pc + 4;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end else begin
      m_halt  = 1'b1;
      m_instr = NOP;
      m_valid = 1'b0;
    end
  end

  task automatic check_model(input string tag);
    chk({tag, ".inst_addr"},   inst_addr,   m_pc);
    chk({tag, ".inst_enable"}, {31'b0, inst_enable}, {31'b0, (!m_halt && !stall && !reset)});
    chk({tag, ".ifid_instr"},  ifid_instr,  m_instr);
    chk({tag, ".ifid_valid"},  {31'b0, ifid_valid},  {31'b0, m_valid});
    if (m_valid) chk({tag, ".ifid_pc4"}, ifid_pc4, m_pc4);
    chk({tag, ".halted"},      {31'b0, halted},      {31'b0, m_halt});
    chk({tag, ".fetch_count"}, fetch_count, m_count);
  endtask

  // Single compare process: outputs are checked mid-cycle on every cycle.
  always @(negedge clk) begin
    if (auto_check) check_model("cyc");
  end

  // Apply the given inputs just after the falling edge, then let one rising edge pass.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk); #1;
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hE3A0_1005;
    mem[1] = 32'hE281_2001;

    // Reset state is visible without any clock edge.
    #2;
    reset = 1'b1; model_reset();
    #1;
    chk("rst.inst_addr",   inst_addr,   32'h0);
    chk("rst.ifid_instr",  ifid_instr,  NOP);
    chk("rst.ifid_valid",  {31'b0, ifid_valid}, 32'h0);
    chk("rst.halted",      {31'b0, halted},     32'h0);
    chk("rst.fetch_count", fetch_count, 32'h0);
    chk("rst.inst_enable", {31'b0, inst_enable}, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    auto_check = 1'b1;

    @(posedge clk); #1;
    chk("e1.ifid_instr", ifid_instr, 32'hE3A0_1005);
    chk("e1.ifid_pc4",   ifid_pc4,   32'h4);
    chk("e1.ifid_valid", {31'b0, ifid_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("e2.ifid_instr",  ifid_instr,  32'hE281_2001);
    chk("e2.ifid_pc4",    ifid_pc4,    32'h8);
    chk("e2.inst_addr",   inst_addr,   32'h8);
    chk("e2.fetch_count", fetch_count, 32'h2);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall.inst_addr",   inst_addr,   32'h8);
      chk("stall.ifid_instr",  ifid_instr,  32'hE281_2001);
      chk("stall.fetch_count", fetch_count, 32'h2);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("unstall.ifid_instr", ifid_instr, mem[2]);
    chk("unstall.ifid_pc4",   ifid_pc4,   32'hC);

    step(1'b1, 1'b1, 32'h43);
    chk("br.inst_addr",   inst_addr,   32'h40);
    chk("br.ifid_instr",  ifid_instr,  NOP);
    chk("br.ifid_valid",  {31'b0, ifid_valid}, 32'h0);
    chk("br.fetch_count", fetch_count, 32'h3);

    for (int i = 0; i < 47; i++) step(1'b0, 1'b0, 32'h0);
    chk("run.inst_addr", inst_addr, 32'hFC);
    step(1'b0, 1'b0, 32'h0);
    chk("last.ifid_instr", ifid_instr, mem[63]);
    chk("last.ifid_pc4",   ifid_pc4,   32'h100);
    chk("last.ifid_valid", {31'b0, ifid_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("oob.halted",      {31'b0, halted},      32'h1);
    chk("oob.ifid_valid",  {31'b0, ifid_valid},  32'h0);
    chk("oob.inst_enable", {31'b0, inst_enable}, 32'h0);
    chk("oob.inst_addr",   inst_addr,   32'h100);
    step(1'b0, 1'b0, 32'h0);
    chk("halt.hold", inst_addr, 32'h100);
    step(1'b0, 1'b1, 32'h10);
    chk("exit.halted",    {31'b0, halted}, 32'h0);
    chk("exit.inst_addr", inst_addr,       32'h10);
    step(1'b0, 1'b1, 32'h200);
    chk("far.halted",      {31'b0, halted},      32'h1);
    chk("far.inst_addr",   inst_addr,            32'h200);
    chk("far.inst_enable", {31'b0, inst_enable}, 32'h0);
    step(1'b0, 1'b1, 32'hFF);
    chk("edge.halted",    {31'b0, halted}, 32'h0);
    chk("edge.inst_addr", inst_addr,       32'hFC);

    // Asynchronous reset in the middle of a cycle
    step(1'b0, 1'b1, 32'h18);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("pre.inst_addr",  inst_addr, 32'h20);
    chk("pre.ifid_valid", {31'b0, ifid_valid}, 32'h1);
    #1;
    reset = 1'b1; model_reset();
    #1;
    chk("arst.inst_addr",   inst_addr,  32'h0);
    chk("arst.ifid_valid",  {31'b0, ifid_valid}, 32'h0);
    chk("arst.ifid_instr",  ifid_instr, NOP);
    chk("arst.fetch_count", fetch_count, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       branch_target = $urandom;
        1:       branch_target = 32'hF0 + $urandom_range(0, 31);
        default: branch_target = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b1; model_reset();
        #1;
        chk("rnd.arst.inst_addr",   inst_addr,   32'h0);
        chk("rnd.arst.fetch_count", fetch_count, 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
      end
    end

    @(negedge clk); #1;
    auto_check = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage ARM pipeline, directly upstream of the byte-addressed instruction memory. Holds the PC and drives the instruction-memory address. Captures the returned big-endian word into the IF/ID pipeline register. Handles hazard-unit stalls, branch redirect/flush, and out-of-range fetch halting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_LIMIT, 256, instruction-memory size in bytes; a fetch at PC > ADDR_LIMIT-4 is out of range
NOP_INSTR, 32'hE1A0_0000, bubble instruction (MOV r0,r0) inserted on flush/halt/reset

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
branch_taken  input  1  branch resolved taken this cycle
branch_target  input  32  byte address of branch destination
inst_data  input  32  word returned by instruction memory (combinational, same cycle)
inst_addr  output  32  byte address to instruction memory (= PC)
inst_enable  output  1  fetch request qualifier
ifid_instr  output  32  IF/ID instruction
ifid_pc4  output  32  IF/ID PC+4 of the captured instruction
ifid_valid  output  1  IF/ID holds a real fetched instruction
halted  output  1  high while in HALT
fetch_count  output  32  number of valid instructions captured, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values, applied immediately on reset assertion:
  - pc=RESET_PC, state=RUN
  - ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0
  - halted=0, fetch_count=0
- inst_addr = pc at all times. inst_enable = (state==RUN) && !stall && !reset.
- States:
  - RUN: normal fetch.
  - HALT: pc out of range; fetch suppressed.
- Per-edge priority: reset > branch_taken > stall > normal.
- branch_taken=1 (any state, overrides stall):
  - pc <= {branch_target[31:2],2'b00} (low bits forced to 0).
  - IF/ID <= NOP_INSTR with ifid_valid=0 (flush).
  - Next state: RUN if the forced target <= ADDR_LIMIT-4, else HALT.
- stall=1, no branch: pc, IF/ID, state and fetch_count all hold.
- Normal edge in RUN with pc <= ADDR_LIMIT-4:
  - ifid_instr <= inst_data, ifid_pc4 <= pc+4, ifid_valid <= 1.
  - pc <= pc+4; fetch_count increments, saturating at 32'hFFFF_FFFF.
- Normal edge in RUN with pc > ADDR_LIMIT-4:
  - state <= HALT; IF/ID <= NOP_INSTR with ifid_valid=0; pc holds.
- HALT: IF/ID is loaded with the NOP bubble each non-stalled edge. Only branch_taken or reset exits HALT.
- halted is the registered state bit (state==HALT).
- Latency: the instruction at address A appears on ifid_instr one edge after pc==A with no stall.
- Arithmetic: pc+4 is a 32-bit wrapping add; no carry out.
- Reset mid-stall or mid-branch: reset wins; the stall or branch is discarded.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP_INSTR constant.
  - Fetch state encoding: RUN=1'b0, HALT=1'b1.
  - Word width (32) and PC increment (4) constants.
- One sub-module, ifid_reg:
  - Inputs: enable (=!stall || branch_taken), synchronous flush, async active-high reset.
  - Holds instr, pc4, valid.
- fetch_stage keeps the PC, the state machine and the counter.

Test Plan:
- Reset then run; memory holds 0xE3A01005 @0 and 0xE2812001 @4 -> after edge 1: ifid_instr=E3A01005, ifid_pc4=4, ifid_valid=1. After edge 2: ifid_instr=E2812001, ifid_pc4=8, pc=8, fetch_count=2.
- stall=1 for 3 edges with pc=8 -> pc=8, IF/ID and fetch_count unchanged throughout. Deassert stall -> word @8 is captured on the next edge.
- branch_taken=1 with branch_target=0x43 while stall=1 -> next edge: pc=0x40, ifid_instr=E1A00000, ifid_valid=0, fetch_count unchanged.
- Sequential run to pc=0xFC -> word @0xFC is captured. Next edge: halted=1, ifid_valid=0, inst_enable=0. branch_taken to 0x10 -> halted=0, pc=0x10.
- branch_target=0x200 -> HALT on the next edge, pc=0x200, inst_enable=0.
- Assert reset mid-cycle with pc=0x20 and ifid_valid=1 -> pc=0, ifid_valid=0, ifid_instr=E1A00000 and fetch_count=0 immediately, without waiting for a clock edge.
